rtcdate: RTL and testbench

RTCDATE -- requirements
Module: rtcdate

---
 rtl/rtcdate_pkg.sv | 54 +++++
 rtl/rtc_monthlen.sv | 30 +++
 rtl/rtcdate.sv | 102 ++++++++++
 tb/tb_rtcdate.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rtcdate_pkg.sv
// Shared date layout and BCD arithmetic helpers for the calendar date register.
package rtcdate_pkg;

    // Packed BCD date, laid out exactly as the bus register: {year, month, day}.
    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
    } date_t;

    // Written field values that mean "leave this field alone".
    localparam logic [7:0]  KEEP_BYTE = 8'hff;
    localparam logic [15:0] KEEP_YEAR = 16'hffff;

    localparam logic [7:0]  FIRST_DAY  = 8'h01;
    localparam logic [7:0]  LAST_MONTH = 8'h12;

    // Increment a four-digit BCD value; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Increment a two-digit BCD value (day or month).
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [15:0] wide;
        wide = bcd_inc16({8'h00, v});
        return wide[7:0];
    endfunction

    // Two-digit BCD value divisible by 4: even tens need ones of 0/4/8, odd tens need 2/6.
    function automatic logic bcd_div4(input logic [7:0] v);
        logic [3:0] ones;
        ones = v[3:0];
        if (v[4] == 1'b0)
            return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
        else
            return (ones == 4'd2) || (ones == 4'd6);
    endfunction

endpackage

// File: rtl/rtc_monthlen.sv
// Combinational last-day-of-month lookup on BCD year/month, with Gregorian leap years.
module rtc_monthlen
    import rtcdate_pkg::*;
(
    input  logic [15:0] year,
    input  logic [7:0]  month,
    output logic [7:0]  last_day
);

    logic leap_year;

    // Century years are leap only when the century digits are divisible by 4.
    always_comb begin
        if (year[7:0] != 8'h00)
            leap_year = bcd_div4(year[7:0]);
        else
            leap_year = bcd_div4(year[15:8]);
    end

    // Month length table; unknown month codes are treated as 31-day months.
    always_comb begin
        last_day = 8'h31;
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: last_day = 8'h30;
            8'h02:                      last_day = leap_year ? 8'h29 : 8'h28;
            default:                    last_day = 8'h31;
        endcase
    end

endmodule

// File: rtl/rtcdate.sv
// Calendar date register for a real-time clock: advances one day per i_ppd strobe
// and exposes the BCD date as a single Wishbone register.
//
// Bus handshake: a transfer is accepted in every cycle i_wb_stb is high (the
// slave never stalls, so o_wb_stall is constant 0); o_wb_ack answers each
// accepted strobe exactly one cycle later, for reads and writes alike.
// i_wb_cyc carries no extra meaning here. A write takes effect on the same
// edge the strobe is sampled; read data is the registered date, which is
// refreshed every cycle regardless of bus activity.
module rtcdate
    import rtcdate_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DATE = 32'h20000101
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ppd,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data
);

    date_t       r_date = date_t'(DEFAULT_DATE);
    date_t       next_day;
    date_t       wr_date;
    logic [31:0] r_data = DEFAULT_DATE;
    logic        r_ack  = 1'b0;
    logic [7:0]  last_day;
    logic        wr_en;
    date_t       wr_word;
    logic        unused_cyc;

    assign unused_cyc = i_wb_cyc;
    assign wr_en      = i_wb_stb & i_wb_we;
    assign wr_word    = date_t'(i_wb_data);

    rtc_monthlen u_monthlen (
        .year     (r_date.year),
        .month    (r_date.month),
        .last_day (last_day)
    );

    // Tomorrow's date; any day at or past the month length (including garbage
    // written by software) rolls the month over.
    always_comb begin
        next_day = r_date;
        if (r_date.day >= last_day) begin
            next_day.day = FIRST_DAY;
            if (r_date.month >= LAST_MONTH) begin
                next_day.month = 8'h01;
                next_day.year  = bcd_inc16(r_date.year);
            end else begin
                next_day.month = bcd_inc8(r_date.month);
            end
        end else begin
            next_day.day = bcd_inc8(r_date.day);
        end
    end

    // Field-wise write merge: an all-ones field keeps the current value.
    always_comb begin
        wr_date = r_date;
        if (wr_word.year != KEEP_YEAR)
            wr_date.year = wr_word.year;
        if (wr_word.month != KEEP_BYTE)
            wr_date.month = wr_word.month;
        if (wr_word.day != KEEP_BYTE)
            wr_date.day = wr_word.day;
    end

    // Date register: reset beats a write, and a write beats (discards) the day advance.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_date <= date_t'(DEFAULT_DATE);
        else if (wr_en)
            r_date <= wr_date;
        else if (i_ppd)
            r_date <= next_day;
    end

    // Acknowledge every strobe one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_ack <= 1'b0;
        else
            r_ack <= i_wb_stb;
    end

    // Read data follows the date register with one cycle of latency, always.
    always_ff @(posedge i_clk) begin
        r_data <= r_date;
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_data;

endmodule

// File: tb/tb_rtcdate.sv
// Directed bench for the RTC date register: calendar rollovers, leap years,
// masked writes, write/advance collisions and reset priority.
module tb_rtcdate;

    logic        i_clk;
    logic        i_reset;
    logic        i_ppd;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    rtcdate #(.DEFAULT_DATE(32'h20000101)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ppd      (i_ppd),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data)
    );

    // Clock and watchdog.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(negedge i_clk);
    endtask

    // Scoreboard: pop the next expected date and compare with the bus read data.
    task automatic check_date(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        assert (o_wb_data === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o_wb_data, e);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    // Driver: one-cycle write, optionally with a coincident i_ppd; checks ack timing.
    task automatic wb_write(input logic [31:0] d, input logic with_ppd, input string tag);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_data = d;
        i_ppd     = with_ppd;
        cycle();
        check_bit({tag, "_ack"}, o_wb_ack, 1'b1);
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_ppd     = 1'b0;
        cycle();
        check_bit({tag, "_ack_drop"}, o_wb_ack, 1'b0);
    endtask

    // Driver: one-cycle day strobe, then wait for the read register to follow.
    task automatic pulse_ppd();
        i_ppd = 1'b1;
        cycle();
        i_ppd = 1'b0;
        cycle();
    endtask

    task automatic roll(input logic [31:0] start, input logic [31:0] e, input string tag);
        wb_write(start, 1'b0, tag);
        pulse_ppd();
        exp_q.push_back(e);
        check_date(tag);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_ppd     = 1'b1;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_data = 32'h0;

        // Reset held with a day strobe pending.
        cycle();
        cycle();
        i_reset = 1'b0;
        i_ppd   = 1'b0;
        exp_q.push_back(32'h20000101);
        check_date("reset_date");
        check_bit("reset_ack", o_wb_ack, 1'b0);
        check_bit("stall_low", o_wb_stall, 1'b0);

        // Leap-year February and month rollovers.
        wb_write(32'h20240228, 1'b0, "wr_20240228");
        exp_q.push_back(32'h20240228);
        check_date("wr_20240228_data");
        pulse_ppd();
        exp_q.push_back(32'h20240229);
        check_date("leap_2024_29");
        pulse_ppd();
        exp_q.push_back(32'h20240301);
        check_date("leap_2024_0301");

        roll(32'h21000228, 32'h21000301, "century_2100");
        roll(32'h20000228, 32'h20000229, "quad_century_2000");
        roll(32'h19000228, 32'h19000301, "century_1900");
        roll(32'h20230228, 32'h20230301, "plain_2023_feb");
        roll(32'h20990205, 32'h20990206, "day_plain");
        roll(32'h20230109, 32'h20230110, "bcd_09_10");
        roll(32'h20230129, 32'h20230130, "bcd_29_30");
        roll(32'h20230430, 32'h20230501, "apr_30");
        roll(32'h20230131, 32'h20230201, "jan_31");
        roll(32'h20230930, 32'h20231001, "sep_to_oct");
        roll(32'h20991231, 32'h21000101, "year_2099");
        roll(32'h99991231, 32'h00000101, "year_9999_wrap");
        roll(32'h20230645, 32'h20230701, "day_out_of_range");

        // Masked write: only the day field changes.
        wb_write(32'h20230609, 1'b0, "wr_20230609");
        wb_write(32'hffffff15, 1'b0, "wr_mask_day");
        exp_q.push_back(32'h20230615);
        check_date("mask_day");
        wb_write(32'h2031ffff, 1'b0, "wr_mask_md");
        exp_q.push_back(32'h20310615);
        check_date("mask_month_day");

        // Write collides with i_ppd: write wins, advance dropped.
        wb_write(32'h20230430, 1'b1, "wr_with_ppd");
        exp_q.push_back(32'h20230430);
        check_date("write_beats_ppd");
        pulse_ppd();
        exp_q.push_back(32'h20230501);
        check_date("ppd_after_collision");

        // i_ppd in the cycle right after a write advances from the new date.
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_data = 32'h20231231;
        cycle();
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_ppd     = 1'b1;
        cycle();
        i_ppd     = 1'b0;
        cycle();
        exp_q.push_back(32'h20240101);
        check_date("ppd_after_write");

        // Read strobe: ack still comes, date unchanged.
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_data = 32'h11111111;
        cycle();
        check_bit("read_ack", o_wb_ack, 1'b1);
        i_wb_stb = 1'b0;
        cycle();
        check_bit("read_ack_drop", o_wb_ack, 1'b0);
        exp_q.push_back(32'h20240101);
        check_date("read_no_change");

        // Reset together with i_ppd and a strobe.
        wb_write(32'h20230719, 1'b0, "wr_20230719");
        i_reset  = 1'b1;
        i_ppd    = 1'b1;
        i_wb_stb = 1'b1;
        cycle();
        i_reset  = 1'b0;
        i_ppd    = 1'b0;
        i_wb_stb = 1'b0;
        check_bit("reset_ack_clear", o_wb_ack, 1'b0);
        cycle();
        exp_q.push_back(32'h20000101);
        check_date("reset_beats_ppd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
